// File: rtl/ram_access_ctrl_pkg.sv
// Shared definitions for the RAM access controller.
// Holds the FSM state enum, the default RAM geometry and the ram_rw encoding.
package ram_access_pkg;

  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned ADDR_W_DEF    = 6;
  localparam int unsigned MEM_DEPTH_DEF = 6;

  // ram_rw encoding
  localparam logic RAM_WRITE = 1'b1;
  localparam logic RAM_READ  = 1'b0;

  typedef enum logic [3:0] {
    IDLE,
    WRITE,
    WR_VERIFY_ISSUE,
    WR_VERIFY_CMP,
    RD_ISSUE,
    RD_CAPTURE,
    RD_OUT,
    DONE,
    REJECT
  } state_e;

endpackage

// File: rtl/ram_access_ctrl.sv
// Burst initiator for a single-port synchronous RAM with one-cycle read latency.
// Client side: request (valid/ready, write flag, start address, length-1),
//   write data (wr_valid/wr_ready/wr_data), read data (rd_valid/rd_ready/rd_data),
//   done pulse at burst end, err pulse on range rejection or verify mismatch.
// RAM side: ram_cs, ram_rw, ram_addr, ram_wdata out; ram_rdata in (registered by the RAM).
// clk rising edge, rst synchronous active-high.
// Optional: define RAM_ACCESS_CTRL_WR_VERIFY_EN to read back and compare every
//   written word before accepting the next one.
module ram_access_ctrl
  import ram_access_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              err,
  output logic              ram_cs,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned EXT_W = ADDR_W + 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   rd_data_d;
  logic [EXT_W-1:0]    end_addr;
  logic                range_bad;
`ifdef RAM_ACCESS_CTRL_WR_VERIFY_EN
  logic [DATA_W-1:0]   vdata_q, vdata_d;
`endif

  // Last address of the requested burst, widened so it cannot wrap
  assign end_addr  = EXT_W'(req_addr) + EXT_W'(req_len);
  assign range_bad = end_addr >= EXT_W'(MEM_DEPTH);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      rd_data <= '0;
`ifdef RAM_ACCESS_CTRL_WR_VERIFY_EN
      vdata_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      rd_data <= rd_data_d;
`ifdef RAM_ACCESS_CTRL_WR_VERIFY_EN
      vdata_q <= vdata_d;
`endif
    end
  end

  // Next-state, counter update and output decode
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    rd_data_d = rd_data;
`ifdef RAM_ACCESS_CTRL_WR_VERIFY_EN
    vdata_d   = vdata_q;
`endif
    req_ready = 1'b0;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    ram_cs    = 1'b0;
    ram_rw    = RAM_READ;
    ram_addr  = '0;
    ram_wdata = '0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d = req_addr;
          rem_d  = req_len;
          if (range_bad)      state_d = REJECT;
          else if (req_write) state_d = WRITE;
          else                state_d = RD_ISSUE;
        end
      end

      // Write data goes straight through to the RAM; a stall costs no RAM cycle
      WRITE: begin
        wr_ready  = 1'b1;
        ram_cs    = wr_valid;
        ram_rw    = wr_valid ? RAM_WRITE : RAM_READ;
        ram_addr  = addr_q;
        ram_wdata = wr_data;
        if (wr_valid) begin
`ifdef RAM_ACCESS_CTRL_WR_VERIFY_EN
          // Address advances only after the read-back of this word
          vdata_d = wr_data;
          state_d = WR_VERIFY_ISSUE;
`else
          if (rem_q == '0) begin
            state_d = DONE;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            rem_d  = rem_q - ADDR_W'(1);
          end
`endif
        end
      end

`ifdef RAM_ACCESS_CTRL_WR_VERIFY_EN
      WR_VERIFY_ISSUE: begin
        ram_cs   = 1'b1;
        ram_rw   = RAM_READ;
        ram_addr = addr_q;
        state_d  = WR_VERIFY_CMP;
      end

      // ram_rdata now holds the word read back; a mismatch flags but does not abort
      WR_VERIFY_CMP: begin
        err = (ram_rdata != vdata_q);
        if (rem_q == '0) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          rem_d   = rem_q - ADDR_W'(1);
          state_d = WRITE;
        end
      end
`endif

      RD_ISSUE: begin
        ram_cs   = 1'b1;
        ram_rw   = RAM_READ;
        ram_addr = addr_q;
        state_d  = RD_CAPTURE;
      end

      // RAM output is valid one cycle after the issue edge
      RD_CAPTURE: begin
        rd_data_d = ram_rdata;
        state_d   = RD_OUT;
      end

      // rd_data is a register, so it stays put while the client stalls
      RD_OUT: begin
        rd_valid = 1'b1;
        if (rd_ready) begin
          if (rem_q == '0) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            rem_d   = rem_q - ADDR_W'(1);
            state_d = RD_ISSUE;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      REJECT: begin
        err     = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
- Initiator for the single-port synchronous RAM interface: drives cs, rw, address and data_in; captures the RAM's registered data_out.
- Converts burst read/write requests into RAM cycles.
- Honours the RAM's one-cycle read latency.
- Sits between a client (test sequencer / datapath) and the RAM.

Parameters:
- DATA_W, 8, RAM word width.
- ADDR_W, 6, RAM address width.
- MEM_DEPTH, 6, number of implemented RAM words; addresses >= MEM_DEPTH are illegal.

Ports:
- clk  in  1  rising-edge clock, shared with the RAM.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  burst request valid.
- req_ready  out  1  controller accepts a request (high only in IDLE).
- req_write  in  1  1 = write burst, 0 = read burst.
- req_addr  in  ADDR_W  start address.
- req_len  in  ADDR_W  burst length minus one (0 means 1 word).
- wr_valid  in  1  write data valid.
- wr_ready  out  1  write data consumed this cycle.
- wr_data  in  DATA_W  write data.
- rd_valid  out  1  read data valid.
- rd_ready  in  1  client takes read data.
- rd_data  out  DATA_W  read data.
- done  out  1  one-cycle pulse at burst end.
- err  out  1  one-cycle pulse: request rejected (range) or verify mismatch.
- ram_cs  out  1  RAM chip select.
- ram_rw  out  1  1 = write, 0 = read.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM data_in.
- ram_rdata  in  DATA_W  RAM data_out (registered in RAM).

Behaviour:
- Reset: state IDLE; all outputs 0 except req_ready=1; internal counters cleared.
  - Reset mid-burst abandons the burst: no done, no err; a partially written burst stays partially written.
- Handshakes are valid/ready; a transfer occurs on a rising edge with both high.
- Request acceptance, IDLE only:
  - Accept a request only when req_valid && req_ready.
  - Capture addr, len and direction.
  - If req_addr + req_len >= MEM_DEPTH (computed at ADDR_W+1 bits): pulse err next cycle, return to IDLE, make no RAM access.
  - Addresses never wrap.
- ram_cs is asserted only in the cycles listed below; at all other times ram_cs=0, ram_rw=0.
- WRITE:
  - wr_ready=1.
  - ram_cs = ram_rw = wr_valid; ram_addr = current address; ram_wdata = wr_data (combinational pass-through).
  - The RAM writes on the edge where wr_valid is high.
  - Each accepted word increments the address and decrements the remaining count.
  - After the last word: DONE.
  - wr_valid low: stall, no RAM access.
- Read sequence per word:
  - RD_ISSUE (ram_cs=1, ram_rw=0, ram_addr=current) -> RD_CAPTURE (register ram_rdata into rd_data) -> RD_OUT (rd_valid=1, held until rd_ready).
  - On rd_ready: next RD_ISSUE, or DONE after the last word.
  - rd_data stays stable while rd_valid && !rd_ready.
  - Minimum 3 cycles per word.
- DONE: done=1 for one cycle, then IDLE with req_ready=1. A request cannot be accepted in the DONE cycle.
- Read-after-write to the same address is never issued on the same edge; one RAM operation per cycle.
- rd_valid and wr_ready are never high simultaneously.

Optional Feature:
- Macro: RAM_ACCESS_CTRL_WR_VERIFY_EN.
- Defined: each written word is followed by RD_ISSUE and RD_CAPTURE on the same address, then a compare with the written word (held in a register).
  - Mismatch pulses err; the burst continues.
  - No rd_valid for verify reads.
  - Write throughput drops to 1 word per 3 cycles; wr_ready is low during verify.
- Undefined: no verify states; err comes only from range rejection.

Decomposition:
- Shared package ram_access_pkg:
  - state enum (IDLE, WRITE, WR_VERIFY_ISSUE, WR_VERIFY_CMP, RD_ISSUE, RD_CAPTURE, RD_OUT, DONE, REJECT);
  - DATA_W/ADDR_W/MEM_DEPTH defaults;
  - RAM_WRITE=1 / RAM_READ=0 constants.
- No sub-module; the address/length counter stays inline.

Test Plan:
- Reset with req_valid=1 held -> all outputs 0, req_ready=1, ram_cs=0; no access until rst drops.
- Write addr=0 len=5, data 0xA0..0xA5, wr_valid continuous -> 6 consecutive ram_cs=rw=1 cycles, addr 0..5, done one cycle after the last word.
- Read addr=1 len=2 with rd_ready stalled 2 cycles on the 2nd word -> rd_data 0xA1, 0xA2 (held stable), 0xA3; done once.
- Request addr=4 len=2 -> err pulse, no ram_cs, req_ready back high within 2 cycles.
- rst asserted during RD_OUT of a 4-word read -> rd_valid=0 next cycle, no done, next request processes normally.
- With WR_VERIFY_EN defined: RAM model forced to corrupt addr 3; write 0x55 to addr 3 -> err pulse after the verify compare, then done.
